// File: rtl/lsu_controller.sv
// Load/store unit controller: bridges the core's execute-stage memory
// instruction to a single-outstanding, ready-strobed word memory port.
// Handles byte-lane placement for stores, sign/zero extension for loads,
// and flags illegal or misaligned accesses without touching memory.
module lsu_controller (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        core_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned BEW  = XLEN / 8;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t            state;
   logic [2:0]        size_q;
   logic [1:0]        off_q;

   logic              illegal_c;
   logic              misaligned_c;
   logic [BEW-1:0]    be_c;
   logic [XLEN-1:0]   wd_c;
   logic [7:0]        rd_byte_c;
   logic [15:0]       rd_half_c;
   logic [XLEN-1:0]   rd_c;

   // Classify the incoming access: unsupported size codes, sub-word stores
   // with an unsigned size, and natural-alignment violations.
   always_comb begin
      illegal_c    = 1'b0;
      misaligned_c = 1'b0;
      case (core_size_i)
         LDST_B:  illegal_c = 1'b0;
         LDST_H:  misaligned_c = core_addr_i[0];
         LDST_W:  misaligned_c = (core_addr_i[1:0] != 2'b00);
         LDST_BU: illegal_c = core_we_i;
         LDST_HU: begin
            illegal_c    = core_we_i;
            misaligned_c = core_addr_i[0];
         end
         default: illegal_c = 1'b1;
      endcase
   end

   // Byte enables and lane-replicated store data from the low size bits
   // (signed and unsigned variants share the same lane placement).
   always_comb begin
      be_c = '0;
      wd_c = '0;
      case (core_size_i[1:0])
         2'd0: begin
            be_c = BEW'(4'b0001 << core_addr_i[1:0]);
            wd_c = {4{core_wd_i[7:0]}};
         end
         2'd1: begin
            be_c = BEW'(4'b0011 << {core_addr_i[1], 1'b0});
            wd_c = {2{core_wd_i[15:0]}};
         end
         2'd2: begin
            be_c = 4'b1111;
            wd_c = core_wd_i;
         end
         default: begin
            be_c = '0;
            wd_c = '0;
         end
      endcase
   end

   // Pick the addressed byte/half out of the returned word and extend it.
   always_comb begin
      rd_byte_c = mem_rd_i[7:0];
      case (off_q)
         2'd0:    rd_byte_c = mem_rd_i[7:0];
         2'd1:    rd_byte_c = mem_rd_i[15:8];
         2'd2:    rd_byte_c = mem_rd_i[23:16];
         default: rd_byte_c = mem_rd_i[31:24];
      endcase
      rd_half_c = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
      case (size_q)
         LDST_B:  rd_c = {{24{rd_byte_c[7]}}, rd_byte_c};
         LDST_H:  rd_c = {{16{rd_half_c[15]}}, rd_half_c};
         LDST_BU: rd_c = {24'd0, rd_byte_c};
         LDST_HU: rd_c = {16'd0, rd_half_c};
         default: rd_c = mem_rd_i;
      endcase
   end

   // Stall follows the request while idle so the core holds from cycle 0;
   // it is released only in DONE, giving the core exactly one advance cycle.
   always_comb begin
      core_stall_o = 1'b0;
      case (state)
         IDLE:    core_stall_o = core_req_i;
         REQ:     core_stall_o = 1'b1;
         default: core_stall_o = 1'b0;
      endcase
   end

   // Access sequencer: IDLE accepts or rejects, REQ holds the memory port
   // until ready, DONE is a one-cycle release back to IDLE.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         size_q     <= '0;
         off_q      <= '0;
         mem_req_o  <= 1'b0;
         mem_we_o   <= 1'b0;
         mem_be_o   <= '0;
         mem_addr_o <= '0;
         mem_wd_o   <= '0;
         core_rd_o  <= '0;
         core_err_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               core_err_o <= 1'b0;
               if (core_req_i) begin
                  if (illegal_c || misaligned_c) begin
                     core_err_o <= 1'b1;
                     state      <= DONE;
                  end else begin
                     mem_req_o  <= 1'b1;
                     mem_we_o   <= core_we_i;
                     mem_be_o   <= be_c;
                     mem_addr_o <= {core_addr_i[31:2], 2'b00};
                     mem_wd_o   <= wd_c;
                     size_q     <= core_size_i;
                     off_q      <= core_addr_i[1:0];
                     state      <= REQ;
                  end
               end
            end
            REQ: begin
               if (mem_ready_i) begin
                  mem_req_o <= 1'b0;
                  if (!mem_we_o) begin
                     core_rd_o <= rd_c;
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               core_err_o <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_controller.sv
// Scoreboard bench for lsu_controller: the stimulus pushes the expected
// memory transaction (or error) per access; a forked monitor pops and
// compares on each memory handshake or error pulse.
module tb_lsu_controller;

   logic        clk_i;
   logic        rst_i;
   logic        core_req_i;
   logic        core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wd_i;
   logic [31:0] core_rd_o;
   logic        core_stall_o;
   logic        core_err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wd_o;
   logic [31:0] mem_rd_i;
   logic        mem_ready_i;

   typedef struct {
      logic        err;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
   } exp_t;

   exp_t sb[$];
   int   n_chk;
   int   n_fail;

   lsu_controller dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .core_req_i   (core_req_i),
      .core_we_i    (core_we_i),
      .core_size_i  (core_size_i),
      .core_addr_i  (core_addr_i),
      .core_wd_i    (core_wd_i),
      .core_rd_o    (core_rd_o),
      .core_stall_o (core_stall_o),
      .core_err_o   (core_err_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wd_o     (mem_wd_o),
      .mem_rd_i     (mem_rd_i),
      .mem_ready_i  (mem_ready_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Pops one expectation per memory handshake or error pulse; the load
   // result is checked on the cycle after the handshake.
   task automatic monitor();
      exp_t        e;
      logic        rd_pend;
      logic [31:0] rd_exp;
      rd_pend = 1'b0;
      rd_exp  = '0;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            if (rd_pend) begin
               check("core_rd", core_rd_o, rd_exp);
               rd_pend = 1'b0;
            end
            if (mem_req_o && mem_ready_i) begin
               if (sb.size() == 0) begin
                  check("unexpected_mem_xfer", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("xfer_not_err", 32'(e.err), 32'd0);
                  check("mem_we",   32'(mem_we_o), 32'(e.we));
                  check("mem_be",   32'(mem_be_o), 32'(e.be));
                  check("mem_addr", mem_addr_o, e.addr);
                  check("mem_wd",   mem_wd_o, e.wd);
                  rd_exp  = e.rd;
                  rd_pend = 1'b1;
               end
            end
            if (core_err_o) begin
               if (sb.size() == 0) begin
                  check("unexpected_err", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("err_expected", 32'(e.err), 32'd1);
                  check("err_no_req", 32'(mem_req_o), 32'd0);
                  check("err_rd_kept", core_rd_o, e.rd);
               end
            end
         end
      end
   endtask

   // One core access; ready is raised after 'delay' REQ cycles, and 'stray'
   // drives ready while no request is outstanding.
   task automatic run(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rdata, input int delay,
                      input logic stray, input logic err, input logic [3:0] be,
                      input logic [31:0] mwd, input logic [31:0] rd);
      exp_t e;
      int   stall_cnt;
      int   req_cyc;
      int   stable;
      int   waited;
      logic done;
      stall_cnt = 0;
      req_cyc   = 0;
      stable    = 0;
      waited    = 0;
      done      = 1'b0;
      @(posedge clk_i);
      #1;
      core_req_i  = 1'b1;
      core_we_i   = we;
      core_size_i = sz;
      core_addr_i = addr;
      core_wd_i   = wd;
      mem_rd_i    = rdata;
      mem_ready_i = stray;
      e.err  = err;
      e.we   = we;
      e.be   = be;
      e.addr = addr & 32'hFFFF_FFFC;
      e.wd   = mwd;
      e.rd   = rd;
      sb.push_back(e);
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge clk_i);
         if (!core_stall_o) begin
            done = 1'b1;
         end else begin
            stall_cnt++;
            if (mem_req_o) begin
               req_cyc++;
               if (mem_we_o == we && mem_be_o == be && mem_addr_o == e.addr && mem_wd_o == mwd)
                  stable++;
            end
            @(posedge clk_i);
            #1;
            if (mem_req_o) begin
               waited++;
               mem_ready_i = (waited > delay);
            end else begin
               mem_ready_i = stray;
            end
         end
      end
      check("stall_released", 32'(done), 32'd1);
      check("stall_cycles", 32'(stall_cnt), err ? 32'd1 : 32'(delay + 2));
      check("req_cycles", 32'(req_cyc), err ? 32'd0 : 32'(delay + 1));
      check("req_stable", 32'(stable), err ? 32'd0 : 32'(delay + 1));
   endtask

   task automatic idle(input int n);
      @(posedge clk_i);
      #1;
      core_req_i  = 1'b0;
      mem_ready_i = 1'b0;
      repeat (n - 1) @(posedge clk_i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk       = 0;
      n_fail      = 0;
      rst_i       = 1'b1;
      core_req_i  = 1'b0;
      core_we_i   = 1'b0;
      core_size_i = 3'd0;
      core_addr_i = '0;
      core_wd_i   = '0;
      mem_rd_i    = '0;
      mem_ready_i = 1'b0;
      fork
         monitor();
      join_none

      repeat (2) @(negedge clk_i);
      check("rst_mem_req",  32'(mem_req_o), 32'd0);
      check("rst_mem_we",   32'(mem_we_o), 32'd0);
      check("rst_mem_be",   32'(mem_be_o), 32'd0);
      check("rst_mem_addr", mem_addr_o, 32'd0);
      check("rst_mem_wd",   mem_wd_o, 32'd0);
      check("rst_core_rd",  core_rd_o, 32'd0);
      check("rst_core_err", 32'(core_err_o), 32'd0);
      check("rst_stall",    32'(core_stall_o), 32'd0);
      rst_i = 1'b0;
      idle(2);

      // Loads: word, signed/unsigned byte, signed/unsigned half
      run(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF);
      idle(2);
      run(1'b0, 3'd0, 32'h103, 32'h0, 32'h80112233, 0, 1'b0, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80);
      idle(1);
      run(1'b0, 3'd4, 32'h103, 32'h0, 32'h80112233, 0, 1'b0, 1'b0, 4'b1000, 32'h0, 32'h00000080);
      idle(1);
      run(1'b0, 3'd5, 32'h102, 32'h0, 32'h80112233, 0, 1'b0, 1'b0, 4'b1100, 32'h0, 32'h00008011);
      idle(1);
      run(1'b0, 3'd1, 32'h102, 32'h0, 32'h80112233, 1, 1'b0, 1'b0, 4'b1100, 32'h0, 32'hFFFF8011);
      idle(1);

      // Stores leave the load result untouched
      run(1'b1, 3'd0, 32'h201, 32'h000000A5, 32'h0, 3, 1'b0, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'hFFFF8011);
      idle(1);
      run(1'b1, 3'd1, 32'h202, 32'h0000BEEF, 32'h0, 1, 1'b0, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'hFFFF8011);
      idle(1);

      // Misaligned / illegal accesses
      run(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'hFFFF8011);
      idle(1);
      run(1'b1, 3'd5, 32'h200, 32'h1234, 32'h0, 0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'hFFFF8011);
      idle(1);
      run(1'b0, 3'd3, 32'h000, 32'h0, 32'h0, 0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'hFFFF8011);
      idle(1);

      // Back-to-back with ready held high throughout
      run(1'b0, 3'd2, 32'h400, 32'h0, 32'h11223344, 0, 1'b1, 1'b0, 4'b1111, 32'h0, 32'h11223344);
      run(1'b1, 3'd2, 32'h404, 32'hCAFEF00D, 32'h0, 0, 1'b1, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h11223344);
      run(1'b0, 3'd2, 32'h408, 32'h0, 32'h55667788, 0, 1'b1, 1'b0, 4'b1111, 32'h0, 32'h55667788);
      idle(2);

      // Reset while a request is outstanding
      @(posedge clk_i);
      #1;
      core_req_i  = 1'b1;
      core_we_i   = 1'b0;
      core_size_i = 3'd2;
      core_addr_i = 32'h300;
      mem_ready_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      check("midreq_req", 32'(mem_req_o), 32'd1);
      #1;
      rst_i      = 1'b1;
      core_req_i = 1'b0;
      #1;
      check("midreq_rst_req",   32'(mem_req_o), 32'd0);
      check("midreq_rst_stall", 32'(core_stall_o), 32'd0);
      check("midreq_rst_rd",    core_rd_o, 32'd0);
      check("midreq_rst_err",   32'(core_err_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      idle(2);

      run(1'b0, 3'd2, 32'h010, 32'h0, 32'hA5A55A5A, 0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'hA5A55A5A);
      idle(3);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
